// File: rtl/dma_ctrl.sv
// dma_ctrl: single-channel word DMA. Reads LEN words from SRC into a small
// prefetch FIFO and writes them out to DST, both address streams wrapping
// modulo 2^ADDR_WIDTH. Optional irq output is enabled by defining
// DMA_CTRL_IRQ_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no transfer; waits for a CTRL start
// S_RUN   | issuing reads and writes until the last write is granted
// S_ABORT | transfer abandoned; draining outstanding read returns
module dma_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_wdata,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_gnt,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_req,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_gnt,
    output logic                  busy,
    output logic                  done,
    output logic                  err
`ifdef DMA_CTRL_IRQ_EN
    ,
    output logic                  irq
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ABORT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic [15:0]           len_q, len_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [15:0]           rd_rem_q, rd_rem_d, wr_rem_q, wr_rem_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_mem_d [FIFO_DEPTH];
    logic                  done_q, done_d, err_q, err_d;
    logic                  abort_entry;

    logic cfg_ctrl, start_w, abort_w;
    logic rd_fire, wr_fire, push, ret;

    // Only the low bits of config data are stored; the rest is ignored.
    if (DATA_WIDTH > 16) begin : g_unused
        logic unused_cfg_hi;
        assign unused_cfg_hi = ^cfg_wdata[DATA_WIDTH-1:16];
    end

    assign cfg_ctrl = cfg_we && (cfg_addr == 2'd3);
    assign start_w  = cfg_ctrl && cfg_wdata[0];
    assign abort_w  = cfg_ctrl && cfg_wdata[1];

    // Requests depend only on registered state, so they hold steady until granted.
    assign rd_req  = (state_q == S_RUN) && (rd_rem_q != 16'd0) &&
                     (({1'b0, fifo_cnt_q} + {1'b0, outst_q}) < DEPTH_L);
    assign wr_req  = (state_q == S_RUN) && (fifo_cnt_q != '0);
    assign rd_addr = rd_addr_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = fifo_mem_q[rptr_q];
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign err     = err_q;

    assign rd_fire = rd_req && rd_gnt;
    assign wr_fire = wr_req && wr_gnt;
    assign push    = rd_valid && (state_q == S_RUN);
    assign ret     = rd_valid && (state_q != S_IDLE);

    // Next-state: shadow registers, datapath counters, FIFO and FSM transitions.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        rd_rem_d    = rd_rem_q;
        wr_rem_d    = wr_rem_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        fifo_mem_d  = fifo_mem_q;
        done_d      = 1'b0;
        err_d       = err_q;
        abort_entry = 1'b0;

        if (cfg_we) begin
            case (cfg_addr)
                2'd0:    src_d = cfg_wdata[ADDR_WIDTH-1:0];
                2'd1:    dst_d = cfg_wdata[ADDR_WIDTH-1:0];
                2'd2:    len_d = cfg_wdata[15:0];
                default: ;
            endcase
        end

        if (rd_fire) begin
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            rd_rem_d  = rd_rem_q - 16'd1;
        end
        outst_d = outst_q + CW'(rd_fire) - CW'(ret);

        if (push) begin
            fifo_mem_d[wptr_q] = rd_data;
            wptr_d             = wptr_q + PW'(1);
        end
        if (wr_fire) begin
            rptr_d    = rptr_q + PW'(1);
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
            wr_rem_d  = wr_rem_q - 16'd1;
        end
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(wr_fire);

        case (state_q)
            S_IDLE: begin
                if (start_w) begin
                    err_d     = 1'b0;
                    rd_addr_d = src_q;
                    wr_addr_d = dst_q;
                    rd_rem_d  = len_q;
                    wr_rem_d  = len_q;
                    if (len_q != 16'd0) state_d = S_RUN;
                    else                done_d  = 1'b1;
                end
            end
            S_RUN: begin
                // Abort wins over a simultaneous final write grant.
                if (abort_w) begin
                    state_d     = S_ABORT;
                    err_d       = 1'b1;
                    abort_entry = 1'b1;
                    fifo_cnt_d  = '0;
                    wptr_d      = '0;
                    rptr_d      = '0;
                end else if (wr_fire && (wr_rem_q == 16'd1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_ABORT: begin
                if (outst_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            rd_rem_q   <= '0;
            wr_rem_q   <= '0;
            outst_q    <= '0;
            fifo_cnt_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fifo_mem_q <= '{default: '0};
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            rd_rem_q   <= rd_rem_d;
            wr_rem_q   <= wr_rem_d;
            outst_q    <= outst_d;
            fifo_cnt_q <= fifo_cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fifo_mem_q <= fifo_mem_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

`ifdef DMA_CTRL_IRQ_EN
    logic irq_q, irq_d;

    // Interrupt: set wins over a same-cycle clear.
    always_comb begin
        irq_d = irq_q;
        if (cfg_ctrl && cfg_wdata[2]) irq_d = 1'b0;
        if (done_d || abort_entry)    irq_d = 1'b1;
    end

    // Interrupt register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign irq = irq_q;
`else
    logic unused_abort_entry;
    assign unused_abort_entry = abort_entry;
`endif

endmodule

// File: tb/tb_dma_ctrl.sv
// Randomized bench for dma_ctrl with a queue-based transfer model and a
// simple in-order memory responder with variable grant and return delays.
module tb_dma_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_addr = 2'd0;
    logic [DW-1:0] cfg_wdata = '0;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt = 1'b0;
    logic          rd_valid = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt = 1'b0;
    logic          busy, done, err;
`ifdef DMA_CTRL_IRQ_EN
    logic          irq;
`endif

    always #5 clk = ~clk;

    dma_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .busy(busy), .done(done), .err(err)
`ifdef DMA_CTRL_IRQ_EN
        , .irq(irq)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [15:0] sh_src, sh_dst, sh_len;
    logic [15:0] exp_rd[$];
    logic [15:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    logic [31:0] pend_data[$];
    int          pend_due[$];
    bit          exp_busy, exp_done, exp_err, aborting;
    int          fifo_model, outst;
    int          rd_grants, wr_grants, done_seen;
    int          rd_pct, wr_pct, val_pct;

    function automatic logic [31:0] src_word(input logic [15:0] a);
        return {a ^ 16'hC3A5, 16'(a * 16'd7 + 16'h1357)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        sh_src = '0; sh_dst = '0; sh_len = '0;
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        pend_data.delete(); pend_due.delete();
        exp_busy = 0; exp_done = 0; exp_err = 0; aborting = 0;
        fifo_model = 0; outst = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
        rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0; wr_gnt = 1'b0;
        #1;
        chk("rst_ctl", {27'd0, rd_req, wr_req, busy, done, err}, 32'd0);
        chk("rst_rd_addr", rd_addr, 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: check outputs at the falling edge, drive inputs, and
    // predict what the following rising edge does.
    task automatic cycle(input bit we, input logic [1:0] addr, input logic [31:0] data);
        bit cur_busy;
        @(negedge clk);
        if (aborting) begin
            chk("abort_done", done, 0);
            if (!busy) begin
                chk("abort_outst", outst, 0);
                aborting = 0;
            end
        end else begin
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
        end
        chk("err", err, exp_err);
        chk("rd_req", rd_req, !aborting && exp_busy && exp_rd.size() != 0 &&
                              (fifo_model + outst < DEPTH));
        chk("wr_req", wr_req, !aborting && exp_busy && fifo_model != 0);
        if (done) done_seen++;

        cfg_we = we; cfg_addr = addr; cfg_wdata = data;
        rd_gnt = ($urandom_range(0, 99) < rd_pct);
        wr_gnt = ($urandom_range(0, 99) < wr_pct);
        rd_valid = 1'b0;
        rd_data = $urandom;
        if (pend_data.size() > 0 && pend_due[0] <= cyc && $urandom_range(0, 99) < val_pct) begin
            rd_valid = 1'b1;
            rd_data = pend_data.pop_front();
            void'(pend_due.pop_front());
            outst--;
            if (!aborting) fifo_model++;
        end

        cur_busy = exp_busy;
        exp_done = 0;
        if (rd_req && rd_gnt) begin
            rd_grants++;
            if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
            else chk("rd_addr", rd_addr, exp_rd.pop_front());
            pend_data.push_back(src_word(rd_addr));
            pend_due.push_back(cyc + 1);
            outst++;
        end
        if (wr_req && wr_gnt) begin
            wr_grants++;
            if (exp_wa.size() == 0) chk("wr_extra", 1, 0);
            else begin
                chk("wr_addr", wr_addr, exp_wa.pop_front());
                chk("wr_data", wr_data, exp_wd.pop_front());
                if (fifo_model > 0) fifo_model--;
                if (exp_wa.size() == 0 && cur_busy) begin
                    exp_done = 1;
                    exp_busy = 0;
                end
            end
        end

        if (we) begin
            case (addr)
                2'd0: sh_src = data[15:0];
                2'd1: sh_dst = data[15:0];
                2'd2: sh_len = data[15:0];
                default: begin
                    if (data[0] && !cur_busy && !aborting) begin
                        exp_err = 0;
                        if (sh_len == 16'd0) exp_done = 1;
                        else begin
                            exp_busy = 1;
                            for (int k = 0; k < int'(sh_len); k++) begin
                                exp_rd.push_back(16'(sh_src + 16'(k)));
                                exp_wa.push_back(16'(sh_dst + 16'(k)));
                                exp_wd.push_back(src_word(16'(sh_src + 16'(k))));
                            end
                        end
                    end
                    if (data[1] && cur_busy) begin
                        aborting = 1;
                        exp_busy = 0;
                        exp_done = 0;
                        exp_err = 1;
                        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
                        fifo_model = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic run(input int budget, input int abort_at, input int restart_at);
        int i;
        i = 0;
        while ((exp_busy || aborting || exp_done) && i < budget) begin
            if (i == abort_at)        cycle(1'b1, 2'd3, 32'h2);
            else if (i == restart_at) cycle(1'b1, 2'd3, 32'h1);
            else                      cycle(1'b0, 2'd0, 32'h0);
            i++;
        end
        if (exp_busy || aborting || exp_done) chk("timeout", 1, 0);
    endtask

    task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        cycle(1'b1, 2'd0, {16'd0, s});
        cycle(1'b1, 2'd1, {16'd0, d});
        cycle(1'b1, 2'd2, {16'd0, l});
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, w0;
        model_clear();
        rd_grants = 0; wr_grants = 0; done_seen = 0;
        rd_pct = 100; wr_pct = 100; val_pct = 100;
        do_reset();

        // Basic 3-word copy, all grants immediate, read latency 1
        setup(16'h0100, 16'h2000, 16'd3);
        d0 = done_seen; w0 = wr_grants;
        cycle(1'b1, 2'd3, 32'h1);
        run(50, -1, -1);
        chk("t1_done_cnt", done_seen - d0, 1);
        chk("t1_writes", wr_grants - w0, 3);

        // Zero-length start
        d0 = done_seen; r0 = rd_grants; w0 = wr_grants;
        cycle(1'b1, 2'd2, 32'h0);
        cycle(1'b1, 2'd3, 32'h1);
        run(10, -1, -1);
        cycle(1'b0, 2'd0, 32'h0);
        chk("t2_done_cnt", done_seen - d0, 1);
        chk("t2_no_rw", (rd_grants - r0) + (wr_grants - w0), 0);

        // Writes stalled: prefetch stops at FIFO_DEPTH
        setup(16'h0400, 16'h3000, 16'd8);
        r0 = rd_grants; w0 = wr_grants;
        wr_pct = 0;
        cycle(1'b1, 2'd3, 32'h1);
        repeat (20) cycle(1'b0, 2'd0, 32'h0);
        chk("t3_reads", rd_grants - r0, DEPTH);
        chk("t3_rd_req", rd_req, 0);
        wr_pct = 100;
        run(100, -1, -1);
        chk("t3_writes", wr_grants - w0, 8);

        // Source address wrap
        setup(16'hFFFE, 16'h1000, 16'd4);
        cycle(1'b1, 2'd3, 32'h1);
        run(60, -1, -1);

        // Abort with two reads outstanding
        setup(16'h0050, 16'h0060, 16'd8);
        r0 = rd_grants; d0 = done_seen;
        rd_pct = 100; val_pct = 0; wr_pct = 0;
        cycle(1'b1, 2'd3, 32'h1);
        repeat (2) cycle(1'b0, 2'd0, 32'h0);
        rd_pct = 0;
        cycle(1'b1, 2'd3, 32'h2);
        chk("t5_grants", rd_grants - r0, 2);
        val_pct = 100;
        run(50, -1, -1);
        chk("t5_err", err, 1);
        chk("t5_no_done", done_seen - d0, 0);
        rd_pct = 100; wr_pct = 100;
        cycle(1'b1, 2'd2, 32'h2);
        cycle(1'b1, 2'd3, 32'h1);
        run(50, -1, -1);
        chk("t5_err_clr", err, 0);

        // Reset in the middle of a transfer
        setup(16'h0200, 16'h0300, 16'd8);
        d0 = done_seen;
        cycle(1'b1, 2'd3, 32'h1);
        repeat (3) cycle(1'b0, 2'd0, 32'h0);
        do_reset();
        chk("t6_no_done", done_seen - d0, 0);
        setup(16'h0700, 16'h0800, 16'd2);
        cycle(1'b1, 2'd3, 32'h1);
        run(50, -1, -1);

        // Random transfers with random stalls, aborts and ignored restarts
        for (int t = 0; t < 40; t++) begin
            int ab;
            rd_pct = $urandom_range(20, 100);
            wr_pct = $urandom_range(20, 100);
            val_pct = $urandom_range(20, 100);
            setup(16'($urandom), 16'($urandom), 16'($urandom_range(1, 12)));
            cycle(1'b1, 2'd3, 32'h1);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : -1;
            run(800, ab, int'($urandom_range(0, 20)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 Parameters: DATA_WIDTH, default 32, word width; ADDR_WIDTH, default 16, word address width; FIFO_DEPTH, default 4, prefetch buffer entries (power of 2, >=2).
REQ-002 Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  2  config register select: 0=SRC, 1=DST, 2=LEN, 3=CTRL.
- cfg_wdata  in  DATA_WIDTH  config write data.
- rd_req / rd_addr  out  1 / ADDR_WIDTH  source read request and its address.
- rd_gnt  in  1  read request accepted.
- rd_valid / rd_data  in  1 / DATA_WIDTH  read data return, in order.
- wr_req / wr_addr / wr_data  out  1 / ADDR_WIDTH / DATA_WIDTH  destination write request.
- wr_gnt  in  1  write accepted.
- busy / done / err  out  1 each  transfer active / 1-cycle completion pulse / sticky abort flag.

Function
REQ-003 SRC, DST and LEN (low 16 bits) are shadow registers, writable at any time; writes during a transfer do not affect it.
REQ-004 CTRL write: bit0=start, bit1=abort; bits self-clear, no storage.
REQ-005 FSM states IDLE, RUN, ABORT; IDLE->RUN on start with LEN!=0; RUN->IDLE when the last write is granted; RUN->ABORT on abort; ABORT->IDLE when outstanding reads reach 0.
REQ-006 Start in IDLE copies SRC/DST/LEN into working counters; busy=1 from the next cycle.
REQ-007 Start with LEN==0: done pulses the next cycle, busy stays 0, no rd_req/wr_req.
REQ-008 Start while busy is ignored; abort while IDLE is ignored.
REQ-009 rd_req=1 in RUN while reads remaining>0 and fifo_count+outstanding<FIFO_DEPTH; once asserted, rd_req/rd_addr hold until rd_gnt.
REQ-010 Each rd_gnt: rd_addr+1 (mod 2^ADDR_WIDTH), reads remaining-1, outstanding+1.
REQ-011 Each rd_valid: push rd_data to the FIFO, outstanding-1; rd_gnt and rd_valid in the same cycle leave outstanding unchanged.
REQ-012 wr_req=1 in RUN while the FIFO is non-empty; wr_data=FIFO head; on wr_gnt: pop, wr_addr+1 (wrapping), writes remaining-1.
REQ-013 Push and pop in the same cycle leave fifo_count unchanged; a full FIFO never overflows (guaranteed by REQ-009).
REQ-014 Grant of the final write: done=1 for exactly one cycle and busy=0 in that same next cycle.
REQ-015 Abort in RUN: rd_req and wr_req drop next cycle; the FIFO is flushed; in ABORT, rd_valid returns are discarded; err=1; no done pulse.
REQ-016 err is cleared by the next accepted start.
REQ-017 Minimum read-to-write latency: rd_valid in cycle N allows wr_req in cycle N+1.

Reset
REQ-018 rst_n low asynchronously forces: state IDLE; all outputs 0; SRC/DST/LEN, working counters, FIFO pointers and outstanding count 0. Reset mid-transfer abandons it with no done pulse.
REQ-019 Deassertion is synchronized externally; the block is operational on the first rising edge with rst_n high.

Configuration
REQ-020 Macro DMA_CTRL_IRQ_EN defined: adds output irq (1 bit), set on the done pulse or on abort entry, held until a CTRL write with bit2=1, reset 0; a set and a clear in the same cycle leave irq=1.
REQ-021 Macro DMA_CTRL_IRQ_EN undefined: no irq port; CTRL bit2 is ignored.

Verification
REQ-022 SRC=0x0100, DST=0x2000, LEN=3, start, rd_gnt/wr_gnt tied 1, read latency 1 -> writes 0x2000..0x2002 carry the data read from 0x0100..0x0102; one done pulse; busy falls with done.
REQ-023 LEN=0, start -> done pulses one cycle later; no rd_req or wr_req ever asserted.
REQ-024 LEN=8, wr_gnt held 0 -> exactly FIFO_DEPTH=4 reads granted, then rd_req=0; after wr_gnt is released, all 8 words complete in order.
REQ-025 SRC=0xFFFE, LEN=4 -> rd_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-026 Abort after 2 grants with 2 reads outstanding -> wr_req=0 next cycle; late rd_valid returns dropped; IDLE once outstanding=0; err=1; no done; the next start clears err.
REQ-027 rst_n pulsed low mid-transfer -> all outputs 0 immediately; no done; a subsequent start with LEN=2 completes normally.
